// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the
// command sequencer state encoding.
package alu_pkg;

    localparam int OPND_W = 16;
    localparam int RES_W  = 32;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd0;
    localparam logic [OP_W-1:0] OP_ADD     = 3'd1;
    localparam logic [OP_W-1:0] OP_SUB     = 3'd2;
    localparam logic [OP_W-1:0] OP_MUL     = 3'd3;
    localparam logic [OP_W-1:0] OP_DIV     = 3'd4;
    localparam logic [OP_W-1:0] OP_OR      = 3'd5;
    localparam logic [OP_W-1:0] OP_SHL     = 3'd6;
    localparam logic [OP_W-1:0] OP_XOR     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with fall-through read data. Flags are registered,
// so an entry or a freed slot becomes visible the cycle after it happens.
module alu_cmd_fifo #(
    parameter int WIDTH = 39,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             not_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_s;
    logic             empty_r;
    logic             not_full_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && not_full_r;
    assign pop_ok_s  = pop && !empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign empty     = empty_r;
    assign not_full  = not_full_r;

    // Next occupancy from the qualified push/pop pair.
    always_comb begin
        count_s = count_r;
        if (push_ok_s && !pop_ok_s) begin
            count_s = count_r + CNT_ONE;
        end else if (!push_ok_s && pop_ok_s) begin
            count_s = count_r - CNT_ONE;
        end else begin
            count_s = count_r;
        end
    end

    // Pointers, occupancy and registered flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {(AW+1){1'b0}};
            empty_r    <= 1'b1;
            not_full_r <= 1'b0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r    <= count_s;
            empty_r    <= (count_s == {(AW+1){1'b0}});
            not_full_r <= (count_s != CNT_MAX);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the 16-bit ALU: queues commands, issues them and
// returns tagged results. Define ALU_SEQ_DIV0_CHECK_EN to trap divide-by-zero.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [OPND_W-1:0] cmd_a,
    input  logic [OPND_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [OPND_W-1:0] alu_op1,
    output logic [OPND_W-1:0] alu_op2,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [RES_W-1:0]  alu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err
);
    localparam int ENT_W = OP_W + 2*OPND_W + TAG_W;

    seq_state_e        state_r;
    logic [ENT_W-1:0]  ent_s;
    logic [OP_W-1:0]   ent_op_s;
    logic [OPND_W-1:0] ent_a_s;
    logic [OPND_W-1:0] ent_b_s;
    logic [TAG_W-1:0]  ent_tag_s;
    logic              fifo_empty_s;
    logic              pop_req_s;
    logic              pop_ok_s;
    logic              div0_s;
    logic              imm_s;
    logic [RES_W-1:0]  imm_data_s;

    alu_cmd_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_valid),
        .push_data ({cmd_op, cmd_a, cmd_b, cmd_tag}),
        .pop       (pop_req_s),
        .pop_data  (ent_s),
        .empty     (fifo_empty_s),
        .not_full  (cmd_ready)
    );

    assign {ent_op_s, ent_a_s, ent_b_s, ent_tag_s} = ent_s;

`ifdef ALU_SEQ_DIV0_CHECK_EN
    assign div0_s = (ent_op_s == OP_DIV) && (ent_b_s == {OPND_W{1'b0}});
`else
    assign div0_s = 1'b0;
`endif

    // Commands that never reach the ALU produce their result on the pop edge.
    assign imm_s      = (ent_op_s == OP_ILLEGAL) || div0_s;
    assign imm_data_s = div0_s ? {RES_W{1'b1}} : {RES_W{1'b0}};

    assign pop_req_s = (state_r == ST_IDLE) || ((state_r == ST_HOLD) && res_ready);
    assign pop_ok_s  = pop_req_s && !fifo_empty_s;

    // Sequencer FSM with registered ALU and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            alu_op1   <= {OPND_W{1'b0}};
            alu_op2   <= {OPND_W{1'b0}};
            alu_sel   <= {OP_W{1'b0}};
            res_valid <= 1'b0;
            res_data  <= {RES_W{1'b0}};
            res_tag   <= {TAG_W{1'b0}};
            res_err   <= 1'b0;
        end else if (pop_ok_s) begin
            // res_valid is either already low or being consumed this edge
            res_tag <= ent_tag_s;
            if (imm_s) begin
                res_data  <= imm_data_s;
                res_err   <= 1'b1;
                res_valid <= 1'b1;
                state_r   <= ST_HOLD;
            end else begin
                alu_op1   <= ent_a_s;
                alu_op2   <= ent_b_s;
                alu_sel   <= ent_op_s;
                res_err   <= 1'b0;
                res_valid <= 1'b0;
                state_r   <= ST_ISSUE;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_ISSUE: begin
                    res_data  <= alu_result;
                    res_valid <= 1'b1;
                    state_r   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_HOLD;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
